// File: rtl/load_store_unit.sv
// RISC-V load/store unit: one outstanding access, byte-lane steering, load extension, response timeout.
// Build option LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of force-aligning them.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_base,
   input  logic [XLEN-1:0]   req_offset,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [XLEN-1:0]   mem_address,
   output logic [XLEN/8-1:0] mem_byte_enable,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_resp
);
   localparam int NB = XLEN / 8;
   localparam int LB = $clog2(NB);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMR_INIT = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   // state  | meaning
   // IDLE   | ready for a request
   // ACCESS | strobe asserted, waiting for mem_resp or timeout
   // DONE   | rsp_valid pulse, result registers already updated
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rsp_data_q, rsp_data_d;
   logic [LB-1:0]   off_q, off_d;
   logic [2:0]      f3_q, f3_d;
   logic            store_q, store_d, rsp_err_q, rsp_err_d;
   logic [NB-1:0]   be_q, be_d;
   logic [TW-1:0]   tmr_q, tmr_d;

   logic [XLEN-1:0] ea, shifted, ld_ext;
   logic [LB-1:0]   off_raw, mask, off_al;
   logic [NB-1:0]   be_st;
   logic            legal, misal, bad;

   always_comb begin
      ea      = req_base + req_offset;
      off_raw = ea[LB-1:0];
      mask    = '0;
      be_st   = '0;
      case (req_funct3[1:0])
         2'd0:    begin mask = LB'(3'd0); be_st = NB'(8'h01); end
         2'd1:    begin mask = LB'(3'd1); be_st = NB'(8'h03); end
         2'd2:    begin mask = LB'(3'd3); be_st = NB'(8'h0F); end
         default: begin mask = LB'(3'd7); be_st = NB'(8'hFF); end
      endcase
      misal  = |(off_raw & mask);
      off_al = off_raw & ~mask;
      be_st  = be_st << off_al;
      if (req_store)
         legal = (req_funct3 inside {3'b000, 3'b001, 3'b010}) ||
                 (XLEN == 64 && req_funct3 == 3'b011);
      else
         legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                 (XLEN == 64 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
`ifdef LSU_MISALIGN_TRAP_EN
      bad = !legal || misal;
`else
      bad = !legal;
`endif
   end

   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ld_ext = XLEN'($signed(shifted[7:0]));
         3'b001:  ld_ext = XLEN'($signed(shifted[15:0]));
         3'b010:  ld_ext = XLEN'($signed(shifted[31:0]));
         3'b011:  ld_ext = shifted;
         3'b100:  ld_ext = XLEN'(shifted[7:0]);
         3'b101:  ld_ext = XLEN'(shifted[15:0]);
         3'b110:  ld_ext = XLEN'(shifted[31:0]);
         default: ld_ext = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      off_d      = off_q;
      f3_d       = f3_q;
      store_d    = store_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      tmr_d      = tmr_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = {ea[XLEN-1:LB], {LB{1'b0}}};
               off_d   = off_al;
               f3_d    = req_funct3;
               store_d = req_store;
               be_d    = req_store ? be_st : '1;
               wdata_d = req_store ? (req_wdata << {off_al, 3'b000}) : '0;
               tmr_d   = TMR_INIT;
               if (bad) begin
                  state_d    = DONE;
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (mem_resp) begin
               state_d    = DONE;
               rsp_data_d = store_q ? '0 : ld_ext;
               rsp_err_d  = 1'b0;
            end else if (TIMEOUT > 0 && tmr_q == '0) begin
               state_d    = DONE;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
            end else if (TIMEOUT > 0) begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         off_q      <= '0;
         f3_q       <= '0;
         store_q    <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         tmr_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         store_q    <= store_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         tmr_q      <= tmr_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign req_ready       = (state_q == IDLE);
   assign rsp_valid       = (state_q == DONE);
   assign rsp_data        = rsp_data_q;
   assign rsp_err         = rsp_err_q;
   assign mem_read        = (state_q == ACCESS) && !store_q;
   assign mem_write       = (state_q == ACCESS) && store_q;
   assign mem_address     = addr_q;
   assign mem_byte_enable = be_q;
   assign mem_wdata       = wdata_q;
endmodule
